bch_syndrome_frame: RTL
=======================

Name: bch_syndrome_frame

Overview:
- Frame-level syndrome stage for binary BCH decoding.
- Accepts a bit-serial received codeword over a valid/ready stream and counts N bits per frame.
- Computes the odd syndromes S_1, S_3, ..., S_(2T-1) with bit-serial Horner accumulation.
- Hands the complete syndrome set to the downstream error-locator stage through a one-entry valid/ready output buffer, with backpressure.

Parameters:
- M, 4, GF(2^M) field degree; primitive polynomial is the codebase standard for M (M=4: x^4+x+1).
- T, 3, correctable errors; T syndromes are produced, S_(2i+1) for i=0..T-1.
- N, 2^M-1, codeword length in bits; legal range 2..2^M-1 (shortened codes allowed).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a codeword bit.
- in_ready  output  1  block can accept a bit this cycle.
- in_data  input  1  received bit; highest-degree coefficient r_(N-1) first, r_0 last.
- out_valid  output  1  out_syn holds a complete frame's syndromes.
- out_ready  input  1  downstream consumes out_syn this cycle.
- out_syn  output  T*M  packed syndromes; S_(2i+1) in bits [(i+1)*M-1 : i*M], so S_1 is in the LSBs.
- out_err  output  1  OR of all out_syn bits; qualified by out_valid.

Behaviour:
- Reset (rst_n=0 at an edge):
  - bit counter=0, all accumulators=0, state=ACCUM.
  - out_valid=0, out_syn=0, out_err=0.
  - Any partial frame or pending frame is discarded.
  - in_ready=0 during the reset cycle.
- Accept: a bit is taken at an edge where in_valid && in_ready. Nothing changes on a cycle without an accept.
- Accumulation per accepted bit, for each i:
  - first bit of a frame (counter=0): A_i <= in_data placed in bit 0.
  - later bits: A_i <= A_i * alpha^(2i+1) + in_data, with the GF(2^M) multiply reduced by the primitive polynomial and the add as XOR into bit 0.
  - Counter increments and wraps to 0 after N-1.
- States:
  - ACCUM: in_ready=1.
  - PENDING: a finished frame is waiting for the output buffer; in_ready=0.
- Frame completion, on the edge that accepts bit N-1 (counter=N-1), with A_i' the final value including that bit:
  - Output buffer free (out_valid=0, or out_valid && out_ready on the same edge): out_syn <= {A'}, out_valid <= 1, state stays ACCUM. The next frame may start on the following cycle.
  - Output busy (out_valid=1 and out_ready=0): A_i <= A_i', state <= PENDING.
- In PENDING, at the first edge with out_ready=1:
  - out_syn <= A, out_valid stays 1, state <= ACCUM.
  - The counter is already 0, so the next accepted bit starts a new frame.
- Output handshake:
  - out_valid falls only at an edge with out_ready=1 and no new frame loaded on that edge.
  - out_syn and out_err are stable while out_valid=1 and out_ready=0.
- Latency: out_valid is high in the cycle after the edge accepting the last bit, provided the buffer is free.
- Throughput: with in_valid=1 and out_ready=1 held, in_ready stays 1 continuously; one frame every N cycles.
- in_ready depends only on registered state, with no combinational path from out_ready.
- out_err is registered together with out_syn.

Test Plan:
- M=4, T=3, N=15, all-zero codeword streamed, out_ready=1 -> out_valid one cycle after the 15th accept; out_syn=0x000, out_err=0.
- Single error at r_0 (last bit=1, others 0) -> S1=S3=S5=0x1; out_syn=0x111, out_err=1.
- Single error at r_1 (14th bit=1) -> S1=0x2, S3=0x8, S5=0x6; out_syn=0x682.
- Backpressure:
  - frame A has its error at r_0; frame B follows back-to-back and has its error at r_1.
  - out_ready=0 until 5 cycles after frame B's last accept, then raised.
  - Required response: in_ready=0 from the cycle after B's last bit, out_syn holds 0x111 throughout.
  - On the out_ready edge out_syn becomes 0x682 and out_valid stays 1; in_ready returns to 1 the next cycle.
- Reset mid-frame: assert rst_n=0 for one cycle after 7 bits, then stream a full error-at-r_0 frame -> out_syn=0x111 after exactly 15 further accepts; out_valid=0 until then.
- Random in_valid gaps (50%) over 20 frames with random out_ready -> each out_syn matches the reference-model syndromes, with no frames dropped or duplicated.

Source files
------------

// File: rtl/bch_syndrome_frame.sv
// Bit-serial odd-syndrome stage for binary BCH: Horner-accumulates S_1..S_(2T-1)
// over an N-bit frame and hands the set downstream through a one-entry output buffer.

module bch_syndrome_lane #(
    parameter int          M    = 4,
    parameter int          K    = 1,
    parameter logic [M-1:0] POLY = 4'b0011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         accept,
    input  logic         first,
    input  logic         in_data,
    output logic [M-1:0] acc,
    output logic [M-1:0] acc_nxt
);
    function automatic logic [M-1:0] mul_alpha_k(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = a;
        for (int s = 0; s < K; s++)
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
        return r;
    endfunction

    assign acc_nxt = (first ? '0 : mul_alpha_k(acc)) ^ {{(M-1){1'b0}}, in_data};

    always_ff @(posedge clk) begin
        if (!rst_n)      acc <= '0;
        else if (accept) acc <= acc_nxt;
    end
endmodule

module bch_syndrome_frame #(
    parameter int M = 4,
    parameter int T = 3,
    parameter int N = (1 << M) - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [T*M-1:0] out_syn,
    output logic           out_err
);
    // Low M bits of the primitive polynomial (the x^M term is implicit).
    function automatic logic [M-1:0] prim_poly(input int m);
        case (m)
            3:       return M'(32'h03);
            4:       return M'(32'h03);
            5:       return M'(32'h05);
            6:       return M'(32'h03);
            7:       return M'(32'h09);
            8:       return M'(32'h1d);
            default: return M'(32'h03);
        endcase
    endfunction

    localparam logic [M-1:0] POLY = prim_poly(M);
    localparam int           CW   = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {ACCUM, PENDING} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [T-1:0][M-1:0]  acc, acc_nxt;
    logic [T-1:0][M-1:0]  syn_q;
    logic                 accept, last, buf_free, load_new, load_pend;

    assign accept   = in_valid && in_ready;
    assign last     = accept && (cnt == CW'(N - 1));
    assign buf_free = !out_valid || out_ready;

    for (genvar i = 0; i < T; i++) begin : g_lane
        bch_syndrome_lane #(.M(M), .K(2 * i + 1), .POLY(POLY)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .accept  (accept),
            .first   (cnt == '0),
            .in_data (in_data),
            .acc     (acc[i]),
            .acc_nxt (acc_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last && !buf_free) state_nxt = PENDING;
            PENDING: if (out_ready)         state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // in_ready is a function of registered state only; rst_n gates it in the reset cycle.
    always_comb begin
        in_ready  = rst_n && (state == ACCUM);
        load_new  = last && buf_free;
        load_pend = (state == PENDING) && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      cnt <= '0;
        else if (accept) cnt <= last ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            syn_q     <= '0;
            out_err   <= 1'b0;
        end else if (load_new) begin
            out_valid <= 1'b1;
            syn_q     <= acc_nxt;
            out_err   <= |acc_nxt;
        end else if (load_pend) begin
            out_valid <= 1'b1;
            syn_q     <= acc;
            out_err   <= |acc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_syn = syn_q;
endmodule
